uart_mem_loader: RTL

Loads the processing element's operand memories over the board UART. Sits between the UART receiver (byte strobe `rx_valid`/`rx_data`) and the A/B operand memories of the PE memory block. It parses one frame per load: header byte, `DEPTH` 32-bit words for memory A, `DEPTH` words for memory B, then one XOR checksum byte. It reports completion or error to the top level, where the flags are shown on LEDs.

---
 rtl/uart_mem_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_mem_loader.sv
// UART frame loader: header, DEPTH words for memory A, DEPTH words for memory B,
// then an XOR checksum byte. Words are assembled little-endian and written one per strobe.
module uart_mem_loader #(
  parameter int          DEPTH       = 16,
  parameter int          ADDR_W      = 4,
  parameter logic [7:0]  HDR         = 8'hA5,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output logic [7:0]        xor_acc
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_A = 2'd1;
  localparam logic [1:0] S_LOAD_B = 2'd2;
  localparam logic [1:0] S_CHECK  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  // Fires when the incremented count would reach TIMEOUT_CYC.
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       word_q, word_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        xor_q, xor_d;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    addr_d     = addr_q;
    word_d     = word_q;
    idle_cnt_d = idle_cnt_q;
    wr_en_d    = 1'b0;
    wr_sel_d   = wr_sel_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    err_d      = err_q;
    xor_d      = xor_q;

    case (state_q)
      S_IDLE: begin
        idle_cnt_d = '0;
        if (rx_valid && rx_data == HDR) begin
          state_d    = S_LOAD_A;
          done_d     = 1'b0;
          err_d      = 1'b0;
          xor_d      = '0;
          byte_idx_d = '0;
          addr_d     = '0;
        end
      end

      S_LOAD_A, S_LOAD_B: begin
        if (rx_valid) begin
          idle_cnt_d = '0;
          xor_d      = xor_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = rx_data;
            2'd1: word_d[15:8]  = rx_data;
            2'd2: word_d[23:16] = rx_data;
            default: begin
              wr_en_d   = 1'b1;
              wr_sel_d  = (state_q == S_LOAD_B);
              wr_addr_d = addr_q;
              wr_data_d = {rx_data, word_q};
              if (addr_q == LAST_ADDR) begin
                addr_d  = '0;
                state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_CHECK;
              end else begin
                addr_d  = addr_q + ADDR_W'(1);
              end
            end
          endcase
        end else if (idle_cnt_q == TO_LAST) begin
          // Partial word is simply dropped; the next header resets the index.
          err_d      = 1'b1;
          state_d    = S_IDLE;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        if (rx_valid) begin
          if (rx_data == xor_q) done_d = 1'b1;
          else                  err_d  = 1'b1;
          state_d    = S_IDLE;
          idle_cnt_d = '0;
        end else if (idle_cnt_q == TO_LAST) begin
          err_d      = 1'b1;
          state_d    = S_IDLE;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      idle_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_sel_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      xor_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      idle_cnt_q <= idle_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_sel_q   <= wr_sel_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      xor_q      <= xor_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_sel    = wr_sel_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign xor_acc   = xor_q;

endmodule
